dual_port_bram: RTL and testbench
=================================

Name: dual_port_bram

Overview:
- 16 Kbit true dual-port block RAM, behaviourally compatible with the vendor DPB primitive; used as the storage leaf under cache data/tag RAM wrappers.
- Two independent read/write ports, A and B, share one clock. Each port's data width is set separately by parameter, so one port can write wide while the other reads narrow.
- Each port has synchronous reads, a selectable write mode, an optional output pipeline register and a block-select decode.

Parameters:
- READ_MODE0, 0, port A output: 0 = bypass (1-cycle read latency), 1 = pipeline register (2-cycle).
- READ_MODE1, 0, same for port B.
- WRITE_MODE0, 0, port A DO on a write cycle: 0 = normal (hold), 1 = write-through, 2 = read-before-write.
- WRITE_MODE1, 0, same for port B.
- BIT_WIDTH_0, 16, port A data width: 1, 2, 4, 8 or 16. Any other value is an elaboration error.
- BIT_WIDTH_1, 16, same for port B.
- BLK_SEL_0, 3'b000, BLKSELA value that enables port A.
- BLK_SEL_1, 3'b000, BLKSELB value that enables port B.

Ports:
- clk  in  1  clock for both ports and all registers
- rst_n  in  1  synchronous active-low reset
- CEA / CEB  in  1  port clock enable
- WREA / WREB  in  1  1 = write, 0 = read
- RESETA / RESETB  in  1  synchronous active-high per-port output reset
- BLKSELA / BLKSELB  in  3  block select
- OCEA / OCEB  in  1  pipeline output register enable; ignored when READ_MODE = 0
- ADA / ADB  in  14  address; layout depends on port width
- DIA / DIB  in  16  write data; the low W bits are used (W = port width)
- DOA / DOB  out  16  read data; the low W bits are valid, upper bits are 0

Behaviour:
- Storage is 1024 x 16-bit physical words, all zero at time 0.
- Address decode by port width W:
  - W = 16: word address AD[13:4]. AD[1:0] are byte write enables: bit0 controls DI[7:0], bit1 controls DI[15:8]. AD[3:2] are ignored. Reads return the full word.
  - W = 8: unit address AD[13:3].
  - W = 4: unit address AD[13:2].
  - W = 2: unit address AD[13:1].
  - W = 1: unit address AD[13:0].
  - For W < 16, unit n occupies bits [n*W +: W] of the linear 16 Kbit space. For W = 4, nibble AD[3:2] of word AD[13:4].
  - Address bits below the unit granularity are ignored, except the byte enables at W = 16.
- Port active condition: CE = 1 and BLKSEL == BLK_SEL. Inactive ports do not write, and their output latch holds.
- Write, on a posedge with the port active and WRE = 1: the addressed unit (byte-masked at W = 16) is updated. The output latch then behaves per WRITE_MODE:
  - 0: latch holds.
  - 1: latch takes the written data; at W = 16 this is the merged word.
  - 2: latch takes the old contents.
- Read, on a posedge with the port active and WRE = 0: the latch takes the addressed unit, zero-extended to 16 bits.
- Output path:
  - READ_MODE = 0: DO = latch, so data appears 1 cycle after the address.
  - READ_MODE = 1: a second register loads from the latch on posedges where OCE = 1, and DO = that register (2-cycle latency).
- Reset: rst_n = 0 clears all of both ports' output registers to 0 on the same posedge. RESETA or RESETB = 1 clears only that port's output registers.
  - Reset takes priority over latch and pipeline-register loads.
  - Memory contents are not affected by reset; writes issued during reset still commit.
- Collisions are evaluated per overlapping 16-bit word, same cycle:
  - A writes and B writes: port A data wins on overlapping bits, and non-overlapping bits from B still commit.
  - One port writes and the other reads: the reader receives the old data.
- Dual-width use is required to work, e.g. A at W = 16 writing while B at W = 4 reads.

Optional Feature:
- Macro: DPB_COLL_DETECT_EN.
- Defined: adds output coll_err (1 bit, resets to 0). It is registered and pulses high for one cycle after any cycle in which both ports are active on the same physical word and at least one of them is writing. Data semantics are unchanged.
- Not defined: the port does not exist and there is no detection logic.

Test Plan:
- Wide write, narrow read: A is W = 16, B is W = 4.
  - Write ADA = {10'h005, 4'b0011}, DIA = 16'hA5C3.
  - Then read ADB = {10'h005, 2'b01, 2'b00}.
  - Required: DOB = 16'h000C one cycle later; nibble 3 reads 4'hA.
- Byte enable: on the word above, write 16'h1234 with AD[1:0] = 2'b01. Required: readback 16'hA534.
- Write modes on port A:
  - WRITE_MODE0 = 1: DOA = 16'hA5C3 the cycle after the write.
  - WRITE_MODE0 = 2: DOA shows the prior contents.
  - WRITE_MODE0 = 0: DOA holds its previous value.
- READ_MODE1 = 1: read word 16'hA5C3.
  - With OCEB = 1, DOB updates 2 cycles after the address.
  - With OCEB = 0, DOB holds.
- Reset and block select:
  - rst_n = 0 with DOB = 16'h000C: required DOB = 0 next cycle, and a subsequent read still returns 16'h000C.
  - A write with BLKSELA != BLK_SEL_0 leaves memory unchanged.
- Collision: same cycle, A writes 16'hFFFF to word 7 while B reads word 7.
  - Required: B returns the old value; the next read returns 16'hFFFF.
  - coll_err pulses when DPB_COLL_DETECT_EN is defined.

Source files
------------

// File: rtl/dual_port_bram.sv
// True dual-port 1024x16 block RAM, per-port width 1/2/4/8/16, write modes and optional output pipeline.
// Latency: 1 cycle (READ_MODE=0) or 2 cycles (READ_MODE=1, pipeline loads when OCE=1); optional macro DPB_COLL_DETECT_EN adds coll_err.
// Backpressure: none; a port transfers on every posedge it is active (CE=1 and BLKSEL matches), inactive ports hold their output.
module dual_port_bram #(
    parameter int         READ_MODE0  = 0,
    parameter int         READ_MODE1  = 0,
    parameter int         WRITE_MODE0 = 0,
    parameter int         WRITE_MODE1 = 0,
    parameter int         BIT_WIDTH_0 = 16,
    parameter int         BIT_WIDTH_1 = 16,
    parameter logic [2:0] BLK_SEL_0   = 3'b000,
    parameter logic [2:0] BLK_SEL_1   = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        WREA,
    input  logic        WREB,
    input  logic        RESETA,
    input  logic        RESETB,
    input  logic [2:0]  BLKSELA,
    input  logic [2:0]  BLKSELB,
    input  logic        OCEA,
    input  logic        OCEB,
    input  logic [13:0] ADA,
    input  logic [13:0] ADB,
    input  logic [15:0] DIA,
    input  logic [15:0] DIB,
    output logic [15:0] DOA,
    output logic [15:0] DOB
`ifdef DPB_COLL_DETECT_EN
    ,
    output logic        coll_err
`endif
);

    // Reject unsupported port widths at elaboration.
    if (!(BIT_WIDTH_0 inside {1, 2, 4, 8, 16})) begin : g_bad_width_0
        $error("dual_port_bram: BIT_WIDTH_0 must be 1, 2, 4, 8 or 16");
    end
    if (!(BIT_WIDTH_1 inside {1, 2, 4, 8, 16})) begin : g_bad_width_1
        $error("dual_port_bram: BIT_WIDTH_1 must be 1, 2, 4, 8 or 16");
    end

    // A unit of width W at unit address u sits at linear bit u*W, so the
    // physical word is always AD[13:4] and the bit offset is AD[3:0] with the
    // sub-unit bits cleared.
    localparam bit         W16_A   = (BIT_WIDTH_0 == 16);
    localparam bit         W16_B   = (BIT_WIDTH_1 == 16);
    localparam logic [15:0] UMASK_A = W16_A ? 16'hFFFF : 16'((32'd1 << BIT_WIDTH_0) - 32'd1);
    localparam logic [15:0] UMASK_B = W16_B ? 16'hFFFF : 16'((32'd1 << BIT_WIDTH_1) - 32'd1);
    localparam logic [3:0]  OFFM_A  = W16_A ? 4'h0 : 4'(~(BIT_WIDTH_0 - 1));
    localparam logic [3:0]  OFFM_B  = W16_B ? 4'h0 : 4'(~(BIT_WIDTH_1 - 1));

    logic [15:0] mem_q [1024] = '{default: 16'h0000};

    logic        act_a, act_b, wr_a, wr_b;
    logic [9:0]  waddr_a, waddr_b;
    logic [3:0]  off_a, off_b;
    logic [15:0] mask_a, mask_b, wdat_a, wdat_b;
    logic [15:0] old_a, old_b, rd_a, rd_b, wt_a, wt_b;
    logic [15:0] mem_wd_a, mem_wd_b, base_a;
    logic [15:0] dol_a_d, dol_a_q, dol_b_d, dol_b_q;
    logic [15:0] pipe_a_d, pipe_a_q, pipe_b_d, pipe_b_q;

    // Address decode, write masks and merged write words for both ports; A is merged last so it wins on overlap.
    always_comb begin
        act_a   = CEA && (BLKSELA == BLK_SEL_0);
        act_b   = CEB && (BLKSELB == BLK_SEL_1);
        wr_a    = act_a && WREA;
        wr_b    = act_b && WREB;
        waddr_a = ADA[13:4];
        waddr_b = ADB[13:4];
        off_a   = ADA[3:0] & OFFM_A;
        off_b   = ADB[3:0] & OFFM_B;
        mask_a  = W16_A ? {{8{ADA[1]}}, {8{ADA[0]}}} : (UMASK_A << off_a);
        mask_b  = W16_B ? {{8{ADB[1]}}, {8{ADB[0]}}} : (UMASK_B << off_b);
        wdat_a  = W16_A ? DIA : ((DIA & UMASK_A) << off_a);
        wdat_b  = W16_B ? DIB : ((DIB & UMASK_B) << off_b);
        old_a   = mem_q[waddr_a];
        old_b   = mem_q[waddr_b];
        rd_a    = (old_a >> off_a) & UMASK_A;
        rd_b    = (old_b >> off_b) & UMASK_B;
        wt_a    = W16_A ? ((old_a & ~mask_a) | (DIA & mask_a)) : (DIA & UMASK_A);
        wt_b    = W16_B ? ((old_b & ~mask_b) | (DIB & mask_b)) : (DIB & UMASK_B);
        mem_wd_b = (old_b & ~mask_b) | (wdat_b & mask_b);
        base_a   = (wr_b && (waddr_b == waddr_a)) ? mem_wd_b : old_a;
        mem_wd_a = (base_a & ~mask_a) | (wdat_a & mask_a);
    end

    // Storage update; unaffected by reset. A same-word A write carries B's bits already.
    always_ff @(posedge clk) begin
        if (wr_b) mem_q[waddr_b] <= mem_wd_b;
        if (wr_a) mem_q[waddr_a] <= mem_wd_a;
    end

    // Output latch and pipeline next-state; resets override every load.
    always_comb begin
        dol_a_d  = dol_a_q;
        dol_b_d  = dol_b_q;
        pipe_a_d = pipe_a_q;
        pipe_b_d = pipe_b_q;
        if (act_a) begin
            if (!WREA)                 dol_a_d = rd_a;
            else if (WRITE_MODE0 == 1) dol_a_d = wt_a;
            else if (WRITE_MODE0 == 2) dol_a_d = rd_a;
        end
        if (act_b) begin
            if (!WREB)                 dol_b_d = rd_b;
            else if (WRITE_MODE1 == 1) dol_b_d = wt_b;
            else if (WRITE_MODE1 == 2) dol_b_d = rd_b;
        end
        if ((READ_MODE0 == 1) && OCEA) pipe_a_d = dol_a_q;
        if ((READ_MODE1 == 1) && OCEB) pipe_b_d = dol_b_q;
        if (!rst_n || RESETA) begin
            dol_a_d  = 16'h0000;
            pipe_a_d = 16'h0000;
        end
        if (!rst_n || RESETB) begin
            dol_b_d  = 16'h0000;
            pipe_b_d = 16'h0000;
        end
    end

    // Output register state.
    always_ff @(posedge clk) begin
        dol_a_q  <= dol_a_d;
        dol_b_q  <= dol_b_d;
        pipe_a_q <= pipe_a_d;
        pipe_b_q <= pipe_b_d;
    end

    assign DOA = (READ_MODE0 == 1) ? pipe_a_q : dol_a_q;
    assign DOB = (READ_MODE1 == 1) ? pipe_b_q : dol_b_q;

`ifdef DPB_COLL_DETECT_EN
    logic coll_err_d, coll_err_q;

    // Flag both ports on the same physical word with at least one writing.
    always_comb begin
        coll_err_d = act_a && act_b && (WREA || WREB) && (waddr_a == waddr_b);
        if (!rst_n) coll_err_d = 1'b0;
    end

    // One-cycle registered collision pulse.
    always_ff @(posedge clk) begin
        coll_err_q <= coll_err_d;
    end

    assign coll_err = coll_err_q;
`else
    // Collision detection not built.
`endif

endmodule

// File: tb/tb_dual_port_bram.sv
module tb_dual_port_bram;

    logic        clk;
    logic        rst_n;
    logic        cea, ceb, wrea, wreb, reseta, resetb, ocea, oceb;
    logic [2:0]  blksela, blkselb;
    logic [13:0] ada, adb;
    logic [15:0] dia, dib;
    logic [15:0] doa0, dob0, doa1, dob1, doa2, dob2;
`ifdef DPB_COLL_DETECT_EN
    logic        ce0, ce1, ce2;
`endif
    int n_pass = 0;
    int n_fail = 0;

    // d0: A W16 write-through, B W4 bypass
    dual_port_bram #(.READ_MODE0(0), .READ_MODE1(0), .WRITE_MODE0(1), .WRITE_MODE1(0),
                     .BIT_WIDTH_0(16), .BIT_WIDTH_1(4), .BLK_SEL_0(3'b010), .BLK_SEL_1(3'b101)) u_d0 (
        .clk(clk), .rst_n(rst_n), .CEA(cea), .CEB(ceb), .WREA(wrea), .WREB(wreb),
        .RESETA(reseta), .RESETB(resetb), .BLKSELA(blksela), .BLKSELB(blkselb),
        .OCEA(ocea), .OCEB(oceb), .ADA(ada), .ADB(adb), .DIA(dia), .DIB(dib),
        .DOA(doa0), .DOB(dob0)
`ifdef DPB_COLL_DETECT_EN
        , .coll_err(ce0)
`endif
    );

    // d1: A W16 read-before-write, B W16 pipelined
    dual_port_bram #(.READ_MODE0(0), .READ_MODE1(1), .WRITE_MODE0(2), .WRITE_MODE1(0),
                     .BIT_WIDTH_0(16), .BIT_WIDTH_1(16), .BLK_SEL_0(3'b010), .BLK_SEL_1(3'b101)) u_d1 (
        .clk(clk), .rst_n(rst_n), .CEA(cea), .CEB(ceb), .WREA(wrea), .WREB(wreb),
        .RESETA(reseta), .RESETB(resetb), .BLKSELA(blksela), .BLKSELB(blkselb),
        .OCEA(ocea), .OCEB(oceb), .ADA(ada), .ADB(adb), .DIA(dia), .DIB(dib),
        .DOA(doa1), .DOB(dob1)
`ifdef DPB_COLL_DETECT_EN
        , .coll_err(ce1)
`endif
    );

    // d2: A W16 normal (hold), B W16 bypass
    dual_port_bram #(.READ_MODE0(0), .READ_MODE1(0), .WRITE_MODE0(0), .WRITE_MODE1(0),
                     .BIT_WIDTH_0(16), .BIT_WIDTH_1(16), .BLK_SEL_0(3'b010), .BLK_SEL_1(3'b101)) u_d2 (
        .clk(clk), .rst_n(rst_n), .CEA(cea), .CEB(ceb), .WREA(wrea), .WREB(wreb),
        .RESETA(reseta), .RESETB(resetb), .BLKSELA(blksela), .BLKSELB(blkselb),
        .OCEA(ocea), .OCEB(oceb), .ADA(ada), .ADB(adb), .DIA(dia), .DIB(dib),
        .DOA(doa2), .DOB(dob2)
`ifdef DPB_COLL_DETECT_EN
        , .coll_err(ce2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic ce, input logic we, input logic [13:0] ad, input logic [15:0] di);
        cea = ce; wrea = we; ada = ad; dia = di;
    endtask

    task automatic drv_b(input logic ce, input logic we, input logic [13:0] ad, input logic [15:0] di);
        ceb = ce; wreb = we; adb = ad; dib = di;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; reseta = 1'b0; resetb = 1'b0; ocea = 1'b0; oceb = 1'b0;
        blksela = 3'b010; blkselb = 3'b101;
        drv_a(1'b0, 1'b0, 14'h0, 16'h0); drv_b(1'b0, 1'b0, 14'h0, 16'h0);
        tick(); tick();
        if (doa0 !== 16'h0000) begin $display("FAIL rst_doa0: got %h want %h", doa0, 16'h0000); n_fail++; end else n_pass++;
        if (dob0 !== 16'h0000) begin $display("FAIL rst_dob0: got %h want %h", dob0, 16'h0000); n_fail++; end else n_pass++;
        if (dob1 !== 16'h0000) begin $display("FAIL rst_dob1: got %h want %h", dob1, 16'h0000); n_fail++; end else n_pass++;
`ifdef DPB_COLL_DETECT_EN
        if (ce2 !== 1'b0) begin $display("FAIL rst_coll: got %b want 0", ce2); n_fail++; end else n_pass++;
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_wide_narrow;
        drv_a(1'b1, 1'b1, {10'h005, 4'b0011}, 16'hA5C3); tick();
        if (doa0 !== 16'hA5C3) begin $display("FAIL wm1_wt: got %h want %h", doa0, 16'hA5C3); n_fail++; end else n_pass++;
        if (doa2 !== 16'h0000) begin $display("FAIL wm0_hold0: got %h want %h", doa2, 16'h0000); n_fail++; end else n_pass++;
        drv_a(1'b0, 1'b0, 14'h0, 16'h0);
        drv_b(1'b1, 1'b0, {10'h005, 2'b01, 2'b00}, 16'h0); tick();
        if (dob0 !== 16'h000C) begin $display("FAIL narrow_n1: got %h want %h", dob0, 16'h000C); n_fail++; end else n_pass++;
        if (dob2 !== 16'hA5C3) begin $display("FAIL wide_rd: got %h want %h", dob2, 16'hA5C3); n_fail++; end else n_pass++;
        if (dob1 !== 16'h0000) begin $display("FAIL pipe_noce: got %h want %h", dob1, 16'h0000); n_fail++; end else n_pass++;
        drv_b(1'b1, 1'b0, {10'h005, 2'b11, 2'b00}, 16'h0); tick();
        if (dob0 !== 16'h000A) begin $display("FAIL narrow_n3: got %h want %h", dob0, 16'h000A); n_fail++; end else n_pass++;
        drv_b(1'b0, 1'b0, 14'h0, 16'h0);
    endtask

    task automatic test_byte_enable;
        drv_a(1'b1, 1'b1, {10'h005, 4'b0001}, 16'h1234); tick();
        if (doa0 !== 16'hA534) begin $display("FAIL be_wt_merged: got %h want %h", doa0, 16'hA534); n_fail++; end else n_pass++;
        if (doa1 !== 16'hA5C3) begin $display("FAIL be_rbw_old: got %h want %h", doa1, 16'hA5C3); n_fail++; end else n_pass++;
        drv_a(1'b0, 1'b0, 14'h0, 16'h0);
        drv_b(1'b1, 1'b0, {10'h005, 4'b0000}, 16'h0); tick();
        if (dob2 !== 16'hA534) begin $display("FAIL be_readback: got %h want %h", dob2, 16'hA534); n_fail++; end else n_pass++;
        if (dob0 !== 16'h0004) begin $display("FAIL be_nibble0: got %h want %h", dob0, 16'h0004); n_fail++; end else n_pass++;
        drv_b(1'b0, 1'b0, 14'h0, 16'h0);
    endtask

    task automatic test_write_modes;
        drv_a(1'b1, 1'b0, {10'h005, 4'b0000}, 16'h0); tick();
        if (doa2 !== 16'hA534) begin $display("FAIL a_read: got %h want %h", doa2, 16'hA534); n_fail++; end else n_pass++;
        drv_a(1'b1, 1'b1, {10'h005, 4'b0011}, 16'hBEEF); tick();
        if (doa0 !== 16'hBEEF) begin $display("FAIL wm1_new: got %h want %h", doa0, 16'hBEEF); n_fail++; end else n_pass++;
        if (doa1 !== 16'hA534) begin $display("FAIL wm2_old: got %h want %h", doa1, 16'hA534); n_fail++; end else n_pass++;
        if (doa2 !== 16'hA534) begin $display("FAIL wm0_hold: got %h want %h", doa2, 16'hA534); n_fail++; end else n_pass++;
        drv_a(1'b0, 1'b0, 14'h0, 16'h0);
    endtask

    task automatic test_read_pipeline;
        drv_a(1'b1, 1'b1, {10'h006, 4'b0011}, 16'hA5C3); tick();
        drv_a(1'b0, 1'b0, 14'h0, 16'h0);
        oceb = 1'b1; drv_b(1'b1, 1'b0, {10'h006, 4'b0000}, 16'h0); tick();
        if (dob1 !== 16'hA534) begin $display("FAIL pipe_cyc1: got %h want %h", dob1, 16'hA534); n_fail++; end else n_pass++;
        if (dob2 !== 16'hA5C3) begin $display("FAIL bypass_cyc1: got %h want %h", dob2, 16'hA5C3); n_fail++; end else n_pass++;
        drv_b(1'b0, 1'b0, 14'h0, 16'h0); tick();
        if (dob1 !== 16'hA5C3) begin $display("FAIL pipe_cyc2: got %h want %h", dob1, 16'hA5C3); n_fail++; end else n_pass++;
        oceb = 1'b0; drv_b(1'b1, 1'b0, {10'h005, 4'b0000}, 16'h0); tick();
        drv_b(1'b0, 1'b0, 14'h0, 16'h0); tick();
        if (dob1 !== 16'hA5C3) begin $display("FAIL pipe_hold: got %h want %h", dob1, 16'hA5C3); n_fail++; end else n_pass++;
        oceb = 1'b1; tick();
        if (dob1 !== 16'hBEEF) begin $display("FAIL pipe_release: got %h want %h", dob1, 16'hBEEF); n_fail++; end else n_pass++;
        oceb = 1'b0;
    endtask

    task automatic test_reset_blksel;
        drv_b(1'b1, 1'b0, {10'h006, 2'b01, 2'b00}, 16'h0); tick();
        if (dob0 !== 16'h000C) begin $display("FAIL pre_rst: got %h want %h", dob0, 16'h000C); n_fail++; end else n_pass++;
        drv_b(1'b0, 1'b0, 14'h0, 16'h0);
        rst_n = 1'b0; drv_a(1'b1, 1'b1, {10'h008, 4'b0011}, 16'h1111); tick();
        if (dob0 !== 16'h0000) begin $display("FAIL rst_clr_b0: got %h want %h", dob0, 16'h0000); n_fail++; end else n_pass++;
        if (dob1 !== 16'h0000) begin $display("FAIL rst_clr_pipe: got %h want %h", dob1, 16'h0000); n_fail++; end else n_pass++;
        if (doa0 !== 16'h0000) begin $display("FAIL rst_over_wt: got %h want %h", doa0, 16'h0000); n_fail++; end else n_pass++;
        rst_n = 1'b1; drv_a(1'b0, 1'b0, 14'h0, 16'h0);
        drv_b(1'b1, 1'b0, {10'h006, 2'b01, 2'b00}, 16'h0); tick();
        if (dob0 !== 16'h000C) begin $display("FAIL post_rst_rd: got %h want %h", dob0, 16'h000C); n_fail++; end else n_pass++;
        drv_b(1'b1, 1'b0, {10'h008, 4'b0000}, 16'h0); tick();
        if (dob2 !== 16'h1111) begin $display("FAIL wr_in_rst: got %h want %h", dob2, 16'h1111); n_fail++; end else n_pass++;
        resetb = 1'b1; drv_a(1'b1, 1'b0, {10'h006, 4'b0000}, 16'h0);
        drv_b(1'b1, 1'b0, {10'h006, 4'b0000}, 16'h0); tick();
        if (dob2 !== 16'h0000) begin $display("FAIL resetb_clr: got %h want %h", dob2, 16'h0000); n_fail++; end else n_pass++;
        if (doa2 !== 16'hA5C3) begin $display("FAIL resetb_a_kept: got %h want %h", doa2, 16'hA5C3); n_fail++; end else n_pass++;
        resetb = 1'b0; reseta = 1'b1; drv_b(1'b0, 1'b0, 14'h0, 16'h0); tick();
        if (doa2 !== 16'h0000) begin $display("FAIL reseta_clr: got %h want %h", doa2, 16'h0000); n_fail++; end else n_pass++;
        reseta = 1'b0;
        blksela = 3'b011; drv_a(1'b1, 1'b1, {10'h006, 4'b0011}, 16'hFFFF); tick();
        if (doa0 !== 16'h0000) begin $display("FAIL blksel_a_hold: got %h want %h", doa0, 16'h0000); n_fail++; end else n_pass++;
        blksela = 3'b010; drv_a(1'b0, 1'b0, 14'h0, 16'h0);
        drv_b(1'b1, 1'b0, {10'h006, 4'b0000}, 16'h0); tick();
        if (dob2 !== 16'hA5C3) begin $display("FAIL blksel_no_wr: got %h want %h", dob2, 16'hA5C3); n_fail++; end else n_pass++;
        blkselb = 3'b100; drv_b(1'b1, 1'b0, {10'h008, 4'b0000}, 16'h0); tick();
        if (dob2 !== 16'hA5C3) begin $display("FAIL blksel_b_hold: got %h want %h", dob2, 16'hA5C3); n_fail++; end else n_pass++;
        blkselb = 3'b101; drv_b(1'b0, 1'b0, 14'h0, 16'h0);
    endtask

    task automatic test_collision;
        drv_a(1'b1, 1'b0, {10'h00B, 4'b0000}, 16'h0); drv_b(1'b1, 1'b0, {10'h00C, 4'b0000}, 16'h0); tick();
`ifdef DPB_COLL_DETECT_EN
        if (ce2 !== 1'b0) begin $display("FAIL coll_diff_word: got %b want 0", ce2); n_fail++; end else n_pass++;
`endif
        drv_a(1'b1, 1'b1, {10'h007, 4'b0011}, 16'hFFFF); drv_b(1'b1, 1'b0, {10'h007, 4'b0000}, 16'h0); tick();
        if (dob2 !== 16'h0000) begin $display("FAIL coll_old_b: got %h want %h", dob2, 16'h0000); n_fail++; end else n_pass++;
        if (dob0 !== 16'h0000) begin $display("FAIL coll_old_nib: got %h want %h", dob0, 16'h0000); n_fail++; end else n_pass++;
`ifdef DPB_COLL_DETECT_EN
        if (ce2 !== 1'b1) begin $display("FAIL coll_pulse: got %b want 1", ce2); n_fail++; end else n_pass++;
`endif
        drv_a(1'b0, 1'b0, 14'h0, 16'h0); drv_b(1'b0, 1'b0, 14'h0, 16'h0); tick();
`ifdef DPB_COLL_DETECT_EN
        if (ce2 !== 1'b0) begin $display("FAIL coll_one_cycle: got %b want 0", ce2); n_fail++; end else n_pass++;
`endif
        drv_b(1'b1, 1'b0, {10'h007, 4'b0000}, 16'h0); tick();
        if (dob2 !== 16'hFFFF) begin $display("FAIL coll_new: got %h want %h", dob2, 16'hFFFF); n_fail++; end else n_pass++;
        drv_b(1'b0, 1'b0, 14'h0, 16'h0);
    endtask

    task automatic test_dual_write;
        drv_a(1'b1, 1'b1, {10'h009, 4'b0001}, 16'h12AA); drv_b(1'b1, 1'b1, {10'h009, 4'b0011}, 16'hBBBB); tick();
        if (dob0 !== 16'h000F) begin $display("FAIL b_wm0_hold: got %h want %h", dob0, 16'h000F); n_fail++; end else n_pass++;
`ifdef DPB_COLL_DETECT_EN
        if (ce2 !== 1'b1) begin $display("FAIL coll_ww: got %b want 1", ce2); n_fail++; end else n_pass++;
`endif
        drv_b(1'b0, 1'b0, 14'h0, 16'h0);
        drv_a(1'b1, 1'b0, {10'h009, 4'b0000}, 16'h0); tick();
        if (doa2 !== 16'hBBAA) begin $display("FAIL ww_merge16: got %h want %h", doa2, 16'hBBAA); n_fail++; end else n_pass++;
        if (doa0 !== 16'h00AA) begin $display("FAIL ww_merge4: got %h want %h", doa0, 16'h00AA); n_fail++; end else n_pass++;
        drv_a(1'b0, 1'b0, 14'h0, 16'h0);
        drv_b(1'b1, 1'b1, {10'h00A, 2'b11, 2'b00}, 16'h000D); tick();
        drv_b(1'b0, 1'b0, 14'h0, 16'h0);
        drv_a(1'b1, 1'b0, {10'h00A, 4'b0000}, 16'h0); tick();
        if (doa0 !== 16'hD000) begin $display("FAIL b_nib_wr: got %h want %h", doa0, 16'hD000); n_fail++; end else n_pass++;
        if (doa2 !== 16'h0000) begin $display("FAIL b_no_be: got %h want %h", doa2, 16'h0000); n_fail++; end else n_pass++;
        drv_a(1'b0, 1'b0, 14'h0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_wide_narrow();
        test_byte_enable();
        test_write_modes();
        test_read_pipeline();
        test_reset_blksel();
        test_collision();
        test_dual_write();
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
